mem_stage_lsu: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register.
- Consumes the registered effective address, store data and memory control fields.
- Drives a single-outstanding valid/ready data-bus request and stalls the pipeline while the access is in flight.
- Returns the aligned, size/sign-extended load result towards the MEM/WB register.
- Handles byte-lane steering, alignment checking and a bus watchdog.

---
 rtl/mem_stage_lsu_if.sv | 21 ++
 rtl/mem_stage_lsu.sv | 141 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-bus handshake between the memory-stage LSU (master) and the data memory or fabric (slave).
// Single outstanding request; the request fields stay stable until dbus_ready is seen.
interface mem_stage_lsu_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_ready, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_ready, dbus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-bus access per load/store, stalls the pipe
// while it is in flight, steers store lanes, extends load data and aborts hung accesses.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read_m,
  input  logic                   mem_write_m,
  input  logic [2:0]             funct3_m,
  input  logic [31:0]            addr_m,
  input  logic [31:0]            wd_m,
  mem_stage_lsu_if.master        dbus,
  output logic                   stall_m,
  output logic [31:0]            load_data,
  output logic                   load_valid,
  output logic                   fault,
  output logic                   bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic [15:0] wd_cnt_reg;
  logic [2:0]  ld_f3_reg;
  logic [1:0]  ld_off_reg;

  logic        access;
  logic        illegal_size;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Access decode; only meaningful while IDLE, the later states ignore the inputs.
  always_comb begin
    access       = mem_read_m | mem_write_m;
    illegal_size = (funct3_m[1:0] == 2'b11) | (funct3_m[2] & funct3_m[1]);
    misaligned   = ((funct3_m[1:0] == 2'b01) & addr_m[0]) |
                   ((funct3_m[1:0] == 2'b10) & (addr_m[1:0] != 2'b00));
    fault        = (state_reg == IDLE) & access & (illegal_size | misaligned);
    start        = (state_reg == IDLE) & access & ~illegal_size & ~misaligned;
    stall_m      = start | (state_reg == REQ);
  end

  // Per-lane store steering; loads always enable the whole word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] =
        (funct3_m[1:0] == 2'b00) ? wd_m[7:0] :
        (funct3_m[1:0] == 2'b01) ? wd_m[8*(gi%2) +: 8] :
                                   wd_m[8*gi +: 8];
      assign be_next[gi] =
        ~mem_write_m             ? 1'b1 :
        (funct3_m[1:0] == 2'b00) ? (addr_m[1:0] == 2'(gi)) :
        (funct3_m[1:0] == 2'b01) ? (addr_m[1] == 1'(gi/2)) :
                                   1'b1;
    end
  endgenerate

  always_comb begin
    byte_sel = dbus.dbus_rdata[{ld_off_reg, 3'b000} +: 8];
    half_sel = dbus.dbus_rdata[{ld_off_reg[1], 4'b0000} +: 16];
    case (ld_f3_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dbus.dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      wd_cnt_reg      <= 16'd0;
      ld_f3_reg       <= 3'b000;
      ld_off_reg      <= 2'b00;
      dbus.dbus_req   <= 1'b0;
      dbus.dbus_we    <= 1'b0;
      dbus.dbus_addr  <= 32'd0;
      dbus.dbus_wdata <= 32'd0;
      dbus.dbus_be    <= 4'd0;
      load_data       <= 32'd0;
      load_valid      <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      // Completion pulses live for the single DONE cycle only.
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            dbus.dbus_req   <= 1'b1;
            dbus.dbus_we    <= mem_write_m;
            dbus.dbus_addr  <= {addr_m[31:2], 2'b00};
            dbus.dbus_be    <= be_next;
            dbus.dbus_wdata <= wdata_next;
            ld_f3_reg       <= funct3_m;
            ld_off_reg      <= addr_m[1:0];
            wd_cnt_reg      <= 16'd0;
            state_reg       <= REQ;
          end
        end
        REQ: begin
          if (dbus.dbus_ready) begin
            dbus.dbus_req <= 1'b0;
            if (!dbus.dbus_we) begin
              load_data  <= load_ext;
              load_valid <= 1'b1;
            end
            state_reg <= DONE;
          end else if (wd_cnt_reg == WD_LAST) begin
            dbus.dbus_req <= 1'b0;
            bus_error     <= 1'b1;
            load_data     <= 32'd0;
            state_reg     <= DONE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: each access pushes its expected completion,
// which is popped and compared once the unit leaves its stall.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m, wd_m;
  logic        stall_m, load_valid, fault, bus_error;
  logic [31:0] load_data;

  mem_stage_lsu_if bus_if();

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .addr_m(addr_m), .wd_m(wd_m), .dbus(bus_if),
    .stall_m(stall_m), .load_data(load_data), .load_valid(load_valid),
    .fault(fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lv;
    int          berr;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_ld = 32'd0;

  // Observations of the last access
  int          stall_cnt, req_cnt, lv_cnt, berr_cnt, fault_cnt;
  logic        issue_req, unstable, post_busy;
  logic [31:0] got_data, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wdat,
                            input int rdy_at, input logic [31:0] rd_val, input logic chain);
    logic done;
    stall_cnt = 0; req_cnt = 0; lv_cnt = 0; berr_cnt = 0; fault_cnt = 0;
    unstable = 1'b0; post_busy = 1'b0; got_data = 32'hx;
    @(negedge clk);
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3; addr_m = a; wd_m = wdat;
    #1;
    issue_req = bus_if.dbus_req;
    fault_cnt += int'(fault);
    done = !stall_m;
    if (stall_m) stall_cnt = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_if.dbus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          cap_addr = bus_if.dbus_addr; cap_wdata = bus_if.dbus_wdata;
          cap_be = bus_if.dbus_be; cap_we = bus_if.dbus_we;
        end else if (cap_addr !== bus_if.dbus_addr || cap_wdata !== bus_if.dbus_wdata ||
                     cap_be !== bus_if.dbus_be || cap_we !== bus_if.dbus_we) begin
          unstable = 1'b1;
        end
      end
      lv_cnt += int'(load_valid);
      berr_cnt += int'(bus_error);
      fault_cnt += int'(fault);
      if (stall_m) stall_cnt++;
      else begin
        done = 1'b1;
        got_data = load_data;
      end
      bus_if.dbus_ready = stall_m && bus_if.dbus_req && ((req_cnt - 1) == rdy_at);
      bus_if.dbus_rdata = bus_if.dbus_ready ? rd_val : $urandom;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL access_bound: got still stalled after 40 cycles required completion");
    end
    if (stall_cnt == 0) got_data = load_data;
    mem_read_m = 1'b0; mem_write_m = 1'b0; bus_if.dbus_ready = 1'b0;
    if (!chain) begin
      @(negedge clk);
      post_busy = bus_if.dbus_req | stall_m | load_valid | bus_error | fault;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read_m = 0; mem_write_m = 0; funct3_m = 0; addr_m = 0; wd_m = 0;
    bus_if.dbus_ready = 0; bus_if.dbus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus_if.dbus_req, bus_if.dbus_we, load_valid, fault, bus_error, stall_m} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus_if.dbus_req, bus_if.dbus_we, load_valid, fault, bus_error, stall_m});
    end
    vectors++;
    if ({bus_if.dbus_addr, bus_if.dbus_wdata, bus_if.dbus_be, load_data} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr %h wdata %h be %b ld %h required all zero",
               bus_if.dbus_addr, bus_if.dbus_wdata, bus_if.dbus_be, load_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    exp_t e;
    sb_q.push_back('{lv: 1, berr: 0, data: 32'hDEADBEEF});
    model_ld = 32'hDEADBEEF;
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
    e = sb_q.pop_front();
    $display("LW  addr 00000100 -> addr %h be %b stall %0d ld %h", cap_addr, cap_be, stall_cnt, got_data);
    vectors++;
    if (cap_addr !== 32'h100 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_bus: got addr %h be %b we %b required 00000100 1111 0", cap_addr, cap_be, cap_we);
    end
    vectors++;
    if (stall_cnt !== 2 || req_cnt !== 1) begin
      miscompares++;
      $display("FAIL lw_latency: got stall %0d req %0d required 2 1", stall_cnt, req_cnt);
    end
    vectors++;
    if (lv_cnt !== e.lv || got_data !== e.data || post_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_result: got lv %0d data %h busy %b required %0d %h 0", lv_cnt, got_data, post_busy, e.lv, e.data);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
    logic [31:0] as  [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] rds [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h1234567F, 32'h00008001};
    logic [31:0] exs [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h0000007F, 32'hFFFF8001};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{lv: 1, berr: 0, data: exs[i]});
      model_ld = exs[i];
      run_access(1, 0, f3s[i], as[i], 32'h0, i % 3, rds[i], 0);
      e = sb_q.pop_front();
      $display("LD  f3 %b addr %h rdata %h -> ld %h", f3s[i], as[i], rds[i], got_data);
      vectors++;
      if (lv_cnt !== e.lv || got_data !== e.data || stall_cnt !== 2 + (i % 3)) begin
        miscompares++;
        $display("FAIL load_ext_%0d: got lv %0d data %h stall %0d required %0d %h %0d",
                 i, lv_cnt, got_data, stall_cnt, e.lv, e.data, 2 + (i % 3));
      end
    end
  endtask

  task automatic test_store();
    logic        rds [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b010};
    logic [31:0] as  [5] = '{32'h201, 32'h202, 32'h204, 32'h203, 32'h208};
    logic [31:0] exa [5] = '{32'h200, 32'h200, 32'h204, 32'h200, 32'h208};
    logic [3:0]  exb [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b1111};
    logic [31:0] exw [5] = '{32'h78787878, 32'h56785678, 32'h12345678, 32'h78787878, 32'h12345678};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{lv: 0, berr: 0, data: model_ld});
      run_access(rds[i], 1, f3s[i], as[i], 32'h12345678, (i == 2) ? 2 : 0, 32'h0, 0);
      e = sb_q.pop_front();
      $display("ST  f3 %b addr %h -> addr %h be %b wdata %h we %b", f3s[i], as[i], cap_addr, cap_be, cap_wdata, cap_we);
      vectors++;
      if (cap_addr !== exa[i] || cap_be !== exb[i] || cap_wdata !== exw[i] || cap_we !== 1'b1 || unstable !== 1'b0) begin
        miscompares++;
        $display("FAIL store_bus_%0d: got %h %b %h we %b unstable %b required %h %b %h 1 0",
                 i, cap_addr, cap_be, cap_wdata, cap_we, unstable, exa[i], exb[i], exw[i]);
      end
      vectors++;
      if (lv_cnt !== e.lv || got_data !== e.data || stall_cnt !== ((i == 2) ? 4 : 2)) begin
        miscompares++;
        $display("FAIL store_done_%0d: got lv %0d ld %h stall %0d required %0d %h %0d",
                 i, lv_cnt, got_data, stall_cnt, e.lv, e.data, (i == 2) ? 4 : 2);
      end
    end
  endtask

  task automatic test_fault();
    logic        wrs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b011, 3'b101, 3'b110, 3'b010};
    logic [31:0] as  [5] = '{32'h102, 32'h100, 32'h101, 32'h100, 32'h201};
    for (int i = 0; i < 5; i++) begin
      run_access(~wrs[i], wrs[i], f3s[i], as[i], 32'hCAFEF00D, 0, 32'h0, 0);
      $display("FLT f3 %b addr %h -> fault %0d stall %0d req %0d", f3s[i], as[i], fault_cnt, stall_cnt, req_cnt);
      vectors++;
      if (fault_cnt !== 1 || stall_cnt !== 0 || req_cnt !== 0 || issue_req !== 1'b0 ||
          post_busy !== 1'b0 || load_data !== model_ld) begin
        miscompares++;
        $display("FAIL fault_%0d: got fault %0d stall %0d req %0d busy %b ld %h required 1 0 0 0 %h",
                 i, fault_cnt, stall_cnt, req_cnt, post_busy, load_data, model_ld);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb_q.push_back('{lv: 0, berr: 1, data: 32'h0});
    model_ld = 32'h0;
    run_access(1, 0, 3'b010, 32'h300, 32'h0, -1, 32'h0, 0);
    e = sb_q.pop_front();
    $display("TMO addr 00000300 -> req %0d stall %0d berr %0d ld %h", req_cnt, stall_cnt, berr_cnt, got_data);
    vectors++;
    if (req_cnt !== 4 || stall_cnt !== 5) begin
      miscompares++;
      $display("FAIL timeout_len: got req %0d stall %0d required 4 5", req_cnt, stall_cnt);
    end
    vectors++;
    if (berr_cnt !== e.berr || lv_cnt !== e.lv || got_data !== e.data || post_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_result: got berr %0d lv %0d ld %h busy %b required %0d %0d %h 0",
               berr_cnt, lv_cnt, got_data, post_busy, e.berr, e.lv, e.data);
    end
  endtask

  task automatic test_reset_mid_req();
    logic saw_req;
    @(negedge clk);
    mem_read_m = 1; mem_write_m = 0; funct3_m = 3'b010; addr_m = 32'h400;
    @(negedge clk);
    saw_req = bus_if.dbus_req;
    @(negedge clk);
    reset = 1'b1; mem_read_m = 0;
    @(negedge clk);
    $display("RST mid-REQ -> req before %b after %b stall %b", saw_req, bus_if.dbus_req, stall_m);
    vectors++;
    if (saw_req !== 1'b1 || bus_if.dbus_req !== 1'b0 || stall_m !== 1'b0 ||
        load_valid !== 1'b0 || bus_error !== 1'b0 || bus_if.dbus_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_req: got req %b->%b stall %b lv %b berr %b addr %h required 1->0 0 0 0 0",
               saw_req, bus_if.dbus_req, stall_m, load_valid, bus_error, bus_if.dbus_addr);
    end
    reset = 1'b0;
    model_ld = 32'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus_if.dbus_req, stall_m, load_valid, bus_error} !== 4'b0 || load_data !== model_ld) begin
      miscompares++;
      $display("FAIL reset_quiet: got %b ld %h required 0000 %h",
               {bus_if.dbus_req, stall_m, load_valid, bus_error}, load_data, model_ld);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [2] = '{32'hA5A5_0001, 32'h5A5A_0002};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{lv: 1, berr: 0, data: vals[i]});
      model_ld = vals[i];
      run_access(1, 0, 3'b010, 32'h500 + 32'(4*i), 32'h0, 0, vals[i], (i == 0));
      e = sb_q.pop_front();
      $display("B2B #%0d addr %h -> stall %0d req %0d ld %h", i, cap_addr, stall_cnt, req_cnt, got_data);
      vectors++;
      if (cap_addr !== 32'h500 + 32'(4*i) || stall_cnt !== 2 || req_cnt !== 1 ||
          lv_cnt !== e.lv || got_data !== e.data) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got addr %h stall %0d req %0d lv %0d ld %h required %h 2 1 %0d %h",
                 i, cap_addr, stall_cnt, req_cnt, lv_cnt, got_data, 32'h500 + 32'(4*i), e.lv, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
